cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Two-requester arbiter that shares the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write). It sits between the two cache controllers and main memory and sequences one full line transaction at a time. Requests are level-held until the matching response, in the same style as the cache-to-memory interface. The grant FSM drives the memory port only from registered state.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width in bits
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line data to I-cache
- i_resp  out  1  I-cache transaction complete, 1-cycle pulse
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line writeback request
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback data
- d_rdata  out  LINE_W  line data to D-cache
- d_resp  out  1  D-cache transaction complete, 1-cycle pulse
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_address  out  ADDR_W  latched address of granted request
- pmem_wdata  out  LINE_W  latched write data of granted request
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory transaction complete

## Operation
- States: IDLE, SERVE_I, SERVE_D. Reset → IDLE.
- IDLE: no request → stay. Only i_read → SERVE_I. Only d_read|d_write → SERVE_D. Both → tie rule (Configuration).
- On grant edge: capture address into addr_q; for D write capture d_wdata into wdata_q and op_q=write; else op_q=read.
- d_read and d_write both high: treated as write; d_read ignored.
- SERVE_I: pmem_read=1, pmem_write=0. SERVE_D: pmem_read=~op_q, pmem_write=op_q. IDLE: both 0.
- pmem_address=addr_q, pmem_wdata=wdata_q in all states (reset value 0).
- In SERVE_X with pmem_resp=1: x_resp=1 combinationally same cycle; x_rdata=pmem_rdata; next state IDLE.
- x_rdata = pmem_rdata only in SERVE_X, else 0. i_resp/d_resp never both 1.
- Request dropped before resp: ignored; transaction completes to memory, resp still pulses.
- pmem_resp in IDLE: ignored, no client resp.

## Timing
- Reset values: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=0, d_resp=0, i_rdata=0, d_rdata=0, last_grant=I.
- Reset is asynchronous: mid-transaction assertion forces IDLE and drops pmem strobes immediately; no resp is issued for the aborted request.
- Grant latency: request sampled high in IDLE at edge N → pmem strobe high from cycle N+1.
- Response: client resp in the same cycle as pmem_resp; zero added latency.
- Minimum one IDLE cycle between transactions; back-to-back requests from the other client are granted at the edge ending that IDLE cycle.
- Requester sees resp at cycle M, must deassert by cycle M+1; a request still high in IDLE at M+1 is a new transaction.

## Configuration
- ARB_ROUND_ROBIN_EN defined: last_grant flop updated on every grant; on tie, grant the client not in last_grant (first tie after reset → D).
- Undefined: fixed priority, D-cache always wins ties; last_grant flop absent.

## Test plan
- Lone I read addr 0x0000_1000, pmem_resp after 5 cycles with rdata 0xA5…A5 → pmem_read high cycles 1–5, pmem_address=0x1000, i_resp one pulse, i_rdata=0xA5…A5, d_resp 0.
- Lone D write addr 0x0000_2040, wdata 0x1234…; client changes d_wdata after grant → pmem_write=1, pmem_wdata keeps captured 0x1234…, d_resp one pulse.
- i_read and d_read asserted same cycle, both held → D granted first; after d_resp + one IDLE cycle I granted; with ARB_ROUND_ROBIN_EN, a second tie grants I first.
- d_read=d_write=1 addr 0x3000 → pmem_write=1, pmem_read=0 throughout.
- rst asserted mid SERVE_D (pmem_write=1) → pmem_write=0 same cycle, no d_resp; after release, held request regranted with 1-cycle latency.
- pmem_resp pulse in IDLE → no i_resp/d_resp, state stays IDLE.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the single memory line port between I-cache and D-cache.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie breaking; undefined means D-cache wins every tie.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [LINE_W-1:0] wdata_r;
    logic              op_r;        // 1 = line writeback, 0 = line read
    logic              d_req_s;
    logic              grant_i_s;
    logic              grant_d_s;
    logic              tie_to_d_s;

    assign d_req_s = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_r;             // 0 = I-cache, 1 = D-cache

    // Remember the most recent grant so a tie goes to the other client
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b0;
        end else if (grant_d_s) begin
            last_grant_r <= 1'b1;
        end else if (grant_i_s) begin
            last_grant_r <= 1'b0;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign tie_to_d_s = (last_grant_r == 1'b0);
`else
    assign tie_to_d_s = 1'b1;
`endif

    // Grant decode, next state, memory strobes and client responses
    always_comb begin
        state_next_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = {LINE_W{1'b0}};
        d_rdata      = {LINE_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (i_read && d_req_s) begin
                    grant_d_s = tie_to_d_s;
                    grant_i_s = ~tie_to_d_s;
                end else if (i_read) begin
                    grant_i_s = 1'b1;
                end else if (d_req_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                    grant_d_s = 1'b0;
                end
                if (grant_d_s) begin
                    state_next_s = SERVE_D;
                end else if (grant_i_s) begin
                    state_next_s = SERVE_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                i_rdata   = pmem_rdata;
                if (pmem_resp) begin
                    i_resp       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SERVE_I;
                end
            end
            SERVE_D: begin
                pmem_read  = ~op_r;
                pmem_write = op_r;
                d_rdata    = pmem_rdata;
                if (pmem_resp) begin
                    d_resp       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SERVE_D;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus capture of the granted request's address, op and write data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {LINE_W{1'b0}};
            op_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (grant_d_s) begin
                addr_r <= d_address;
                op_r   <= d_write;
                if (d_write) begin
                    wdata_r <= d_wdata;
                end else begin
                    wdata_r <= wdata_r;
                end
            end else if (grant_i_s) begin
                addr_r  <= i_address;
                op_r    <= 1'b0;
                wdata_r <= wdata_r;
            end else begin
                addr_r  <= addr_r;
                op_r    <= op_r;
                wdata_r <= wdata_r;
            end
        end
    end

    assign pmem_address = addr_r;
    assign pmem_wdata   = wdata_r;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter; expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_cache_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
        i_address = 32'h0; d_address = 32'h0; d_wdata = {LINE_W{1'b0}};
        pmem_rdata = {32{8'h5A}};
        tick(); tick();
        @(negedge clk);
        tests_run++; if (pmem_read !== 1'b0) begin tests_failed++; $display("FAIL rst_pmem_read: got %b expected 0", pmem_read); end
        tests_run++; if (pmem_write !== 1'b0) begin tests_failed++; $display("FAIL rst_pmem_write: got %b expected 0", pmem_write); end
        tests_run++; if (pmem_address !== 32'h0) begin tests_failed++; $display("FAIL rst_pmem_address: got %h expected 0", pmem_address); end
        tests_run++; if (pmem_wdata !== {LINE_W{1'b0}}) begin tests_failed++; $display("FAIL rst_pmem_wdata: got %h expected 0", pmem_wdata); end
        tests_run++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin tests_failed++; $display("FAIL rst_resp: got i=%b d=%b expected 0 0", i_resp, d_resp); end
        tests_run++; if (i_rdata !== {LINE_W{1'b0}} || d_rdata !== {LINE_W{1'b0}}) begin tests_failed++; $display("FAIL rst_rdata: got i=%h d=%h expected 0", i_rdata, d_rdata); end
        tick();
        rst = 1'b0; pmem_rdata = {LINE_W{1'b0}};
    endtask

    task automatic test_i_read();
        logic exp_resp;
        tick();
        i_read = 1'b1; i_address = 32'h0000_1000;
        @(negedge clk);
        tests_run++; if (pmem_read !== 1'b0) begin tests_failed++; $display("FAIL i_pre_grant_read: got %b expected 0", pmem_read); end
        tick();
        for (int k = 1; k <= 5; k++) begin
            exp_resp = (k == 5);
            if (k == 5) begin pmem_resp = 1'b1; pmem_rdata = {32{8'hA5}}; end
            @(negedge clk);
            tests_run++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin tests_failed++; $display("FAIL i_strobe c%0d: got r=%b w=%b expected r=1 w=0", k, pmem_read, pmem_write); end
            tests_run++; if (pmem_address !== 32'h0000_1000) begin tests_failed++; $display("FAIL i_address c%0d: got %h expected 00001000", k, pmem_address); end
            tests_run++; if (i_resp !== exp_resp || d_resp !== 1'b0) begin tests_failed++; $display("FAIL i_resp c%0d: got i=%b d=%b expected i=%b d=0", k, i_resp, d_resp, exp_resp); end
            tick();
        end
        i_read = 1'b0; pmem_resp = 1'b0; pmem_rdata = {LINE_W{1'b0}};
        @(negedge clk);
        tests_run++; if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin tests_failed++; $display("FAIL i_after: got r=%b resp=%b expected 0 0", pmem_read, i_resp); end
    endtask

    task automatic test_i_rdata();
        tick();
        i_read = 1'b1; i_address = 32'h0000_1040;
        tick();
        pmem_resp = 1'b1; pmem_rdata = {32{8'hA5}};
        @(negedge clk);
        tests_run++; if (i_rdata !== {32{8'hA5}}) begin tests_failed++; $display("FAIL i_rdata: got %h expected a5..a5", i_rdata); end
        tests_run++; if (d_rdata !== {LINE_W{1'b0}}) begin tests_failed++; $display("FAIL i_d_rdata_zero: got %h expected 0", d_rdata); end
        tick();
        i_read = 1'b0; pmem_resp = 1'b0; pmem_rdata = {LINE_W{1'b0}};
    endtask

    task automatic test_d_write();
        logic exp_resp;
        tick();
        d_write = 1'b1; d_address = 32'h0000_2040; d_wdata = {8{32'h1234_5678}};
        tick();
        d_wdata = {8{32'hDEAD_BEEF}};
        for (int k = 1; k <= 3; k++) begin
            exp_resp = (k == 3);
            if (k == 3) pmem_resp = 1'b1;
            @(negedge clk);
            tests_run++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin tests_failed++; $display("FAIL dw_strobe c%0d: got r=%b w=%b expected r=0 w=1", k, pmem_read, pmem_write); end
            tests_run++; if (pmem_wdata !== {8{32'h1234_5678}}) begin tests_failed++; $display("FAIL dw_wdata c%0d: got %h expected 12345678..", k, pmem_wdata); end
            tests_run++; if (pmem_address !== 32'h0000_2040) begin tests_failed++; $display("FAIL dw_address c%0d: got %h expected 00002040", k, pmem_address); end
            tests_run++; if (d_resp !== exp_resp || i_resp !== 1'b0) begin tests_failed++; $display("FAIL dw_resp c%0d: got d=%b i=%b expected d=%b i=0", k, d_resp, i_resp, exp_resp); end
            tick();
        end
        d_write = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        tests_run++; if (pmem_write !== 1'b0 || d_resp !== 1'b0) begin tests_failed++; $display("FAIL dw_after: got w=%b resp=%b expected 0 0", pmem_write, d_resp); end
    endtask

    task automatic test_tie();
        logic [ADDR_W-1:0] exp_addr;
        tick();
        i_read = 1'b1; i_address = 32'h0000_1100;
        d_read = 1'b1; d_address = 32'h0000_2200;
        tick();
        @(negedge clk);
        tests_run++; if (pmem_address !== 32'h0000_2200 || pmem_read !== 1'b1) begin tests_failed++; $display("FAIL tie1_grant: got addr=%h r=%b expected 00002200 1", pmem_address, pmem_read); end
        tick();
        pmem_resp = 1'b1; pmem_rdata = {8{32'h0BAD_F00D}};
        @(negedge clk);
        tests_run++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin tests_failed++; $display("FAIL tie1_resp: got d=%b i=%b expected d=1 i=0", d_resp, i_resp); end
        tests_run++; if (d_rdata !== {8{32'h0BAD_F00D}}) begin tests_failed++; $display("FAIL tie1_rdata: got %h expected 0badf00d..", d_rdata); end
        tick();
        d_read = 1'b0; pmem_resp = 1'b0; pmem_rdata = {LINE_W{1'b0}};
        @(negedge clk);
        tests_run++; if (pmem_read !== 1'b0) begin tests_failed++; $display("FAIL tie1_idle_gap: got r=%b expected 0", pmem_read); end
        tick();
        @(negedge clk);
        tests_run++; if (pmem_address !== 32'h0000_1100 || pmem_read !== 1'b1) begin tests_failed++; $display("FAIL tie1_i_next: got addr=%h r=%b expected 00001100 1", pmem_address, pmem_read); end
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        tests_run++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin tests_failed++; $display("FAIL tie1_i_resp: got i=%b d=%b expected i=1 d=0", i_resp, d_resp); end
        tick();
        i_read = 1'b0; pmem_resp = 1'b0;
        d_read = 1'b1; d_address = 32'h0000_2300;
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        tests_run++; if (d_resp !== 1'b1 || pmem_address !== 32'h0000_2300) begin tests_failed++; $display("FAIL lone_d_read: got resp=%b addr=%h expected 1 00002300", d_resp, pmem_address); end
        tick();
        d_read = 1'b0; pmem_resp = 1'b0;
        tick();
        i_read = 1'b1; d_read = 1'b1; d_address = 32'h0000_2200;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        exp_addr = 32'h0000_1100;
`else
        exp_addr = 32'h0000_2200;
`endif
        @(negedge clk);
        tests_run++; if (pmem_address !== exp_addr) begin tests_failed++; $display("FAIL tie2_grant: got addr=%h expected %h", pmem_address, exp_addr); end
        tick();
        pmem_resp = 1'b1;
        tick();
        i_read = 1'b0; d_read = 1'b0; pmem_resp = 1'b0;
    endtask

    task automatic test_rw_both();
        logic exp_resp;
        tick();
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_3000; d_wdata = {8{32'hCAFE_0001}};
        tick();
        for (int k = 1; k <= 2; k++) begin
            exp_resp = (k == 2);
            if (k == 2) pmem_resp = 1'b1;
            @(negedge clk);
            tests_run++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin tests_failed++; $display("FAIL rw_strobe c%0d: got r=%b w=%b expected r=0 w=1", k, pmem_read, pmem_write); end
            tests_run++; if (d_resp !== exp_resp || pmem_address !== 32'h0000_3000) begin tests_failed++; $display("FAIL rw_resp c%0d: got resp=%b addr=%h expected %b 00003000", k, d_resp, pmem_address, exp_resp); end
            tick();
        end
        d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        d_write = 1'b1; d_address = 32'h0000_4000; d_wdata = {8{32'h7777_0000}};
        tick();
        @(negedge clk);
        tests_run++; if (pmem_write !== 1'b1) begin tests_failed++; $display("FAIL rm_before: got w=%b expected 1", pmem_write); end
        #1 rst = 1'b1; pmem_resp = 1'b1;
        #1;
        tests_run++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin tests_failed++; $display("FAIL rm_strobe_drop: got r=%b w=%b expected 0 0", pmem_read, pmem_write); end
        tests_run++; if (d_resp !== 1'b0) begin tests_failed++; $display("FAIL rm_no_resp: got %b expected 0", d_resp); end
        tick();
        rst = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        tests_run++; if (pmem_write !== 1'b0) begin tests_failed++; $display("FAIL rm_idle: got w=%b expected 0", pmem_write); end
        tick();
        @(negedge clk);
        tests_run++; if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_4000) begin tests_failed++; $display("FAIL rm_regrant: got w=%b addr=%h expected 1 00004000", pmem_write, pmem_address); end
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        tests_run++; if (d_resp !== 1'b1) begin tests_failed++; $display("FAIL rm_resp: got %b expected 1", d_resp); end
        tick();
        d_write = 1'b0; pmem_resp = 1'b0;
    endtask

    task automatic test_idle_resp();
        tick();
        pmem_resp = 1'b1; pmem_rdata = {LINE_W{1'b1}};
        @(negedge clk);
        tests_run++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin tests_failed++; $display("FAIL idle_resp: got i=%b d=%b expected 0 0", i_resp, d_resp); end
        tests_run++; if (i_rdata !== {LINE_W{1'b0}} || d_rdata !== {LINE_W{1'b0}}) begin tests_failed++; $display("FAIL idle_rdata: got i=%h d=%h expected 0", i_rdata, d_rdata); end
        tick();
        pmem_resp = 1'b0; pmem_rdata = {LINE_W{1'b0}};
        i_read = 1'b1; i_address = 32'h0000_5000;
        @(negedge clk);
        tests_run++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin tests_failed++; $display("FAIL idle_stays: got r=%b w=%b expected 0 0", pmem_read, pmem_write); end
        tick();
        @(negedge clk);
        tests_run++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_5000) begin tests_failed++; $display("FAIL idle_then_grant: got r=%b addr=%h expected 1 00005000", pmem_read, pmem_address); end
        tick();
        pmem_resp = 1'b1;
        tick();
        i_read = 1'b0; pmem_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i_read();
        test_i_rdata();
        test_d_write();
        test_tie();
        test_rw_both();
        test_reset_mid();
        test_idle_resp();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
